// File: rtl/grf_pkg.sv
// Shared widths and constants for the GPR write-back path.
package grf_pkg;

  localparam int unsigned REG_AW       = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned NREQ_DEFAULT = 3;
  localparam int unsigned NREG         = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [NREQ-1:0] hi_grant;
  logic [NREQ-1:0] lo_grant;
  logic            hi_found;
  logic            lo_found;

  // hi covers indices at/after ptr; lo is the wrapped fallback from index 0.
  always_comb begin
    hi_grant = '0;
    lo_grant = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && !lo_found) begin
        lo_grant[i] = 1'b1;
        lo_found    = 1'b1;
      end
      if (req[i] && (i >= 32'(ptr)) && !hi_found) begin
        hi_grant[i] = 1'b1;
        hi_found    = 1'b1;
      end
    end
    grant = hi_found ? hi_grant : lo_grant;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GPR write-back arbiter: round-robin over requesters, registered write port,
// pending-write scoreboard with operand busy/forward lookups.
module grf_wb_arbiter
  import grf_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*REG_AW-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ*DATA_W-1:0]   req_pc,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rsv_valid,
  input  logic [REG_AW-1:0]        rsv_addr,
  output logic                     rsv_ready,
  input  logic [REG_AW-1:0]        rs_addr,
  input  logic [REG_AW-1:0]        rt_addr,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic                     rs_fwd,
  output logic                     rt_fwd,
  output logic                     wb_we,
  output logic [REG_AW-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [DATA_W-1:0]        wb_pc
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] wb_pc_q, wb_pc_d;

  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic [REG_AW-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] sel_pc;
  logic              hs;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_pc   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_addr = req_addr[i*REG_AW +: REG_AW];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_pc   = req_pc[i*DATA_W +: DATA_W];
      end
    end
  end

  // Handshakes are suppressed combinationally while reset is held low.
  always_comb begin
    req_ready = grant & {NREQ{reset}};
    hs        = |(req_valid & req_ready);
    rsv_ready = reset && ((rsv_addr == REG_ZERO) || !busy_q[rsv_addr]);
    rs_busy   = busy_q[rs_addr];
    rt_busy   = busy_q[rt_addr];
    rs_fwd    = wb_we_q && (wb_addr_q == rs_addr) && (rs_addr != REG_ZERO);
    rt_fwd    = wb_we_q && (wb_addr_q == rt_addr) && (rt_addr != REG_ZERO);
    wb_we     = wb_we_q;
    wb_addr   = wb_addr_q;
    wb_data   = wb_data_q;
    wb_pc     = wb_pc_q;
  end

  always_comb begin
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    wb_we_d   = hs && (sel_addr != REG_ZERO);
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_pc_d   = wb_pc_q;
    if (hs) begin
      ptr_d     = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      wb_addr_d = sel_addr;
      wb_data_d = sel_data;
      wb_pc_d   = sel_pc;
      busy_d[sel_addr] = 1'b0;
    end
    // Set after clear: an unreserved write racing a new reservation of the
    // same register leaves the new reservation in place.
    if (rsv_valid && rsv_ready && (rsv_addr != REG_ZERO)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      busy_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_pc_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_pc_q   <= wb_pc_d;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter with NREQ=3; inputs driven and outputs sampled on negedge.
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [95:0] req_pc;
  logic [2:0]  req_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        rs_fwd;
  logic        rt_fwd;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  grf_wb_arbiter #(.NREQ(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_pc    (req_pc),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .rs_fwd    (rs_fwd),
    .rt_fwd    (rt_fwd),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_pc     (wb_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 3'b111; req_addr = {5'd3, 5'd2, 5'd1};
    req_data = '0; req_pc = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd3; rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    total_cnt++; if (req_ready !== 3'b000) $display("FAIL rst_req_ready: got %b expected 000", req_ready); else pass_cnt++;
    total_cnt++; if (rsv_ready !== 1'b0) $display("FAIL rst_rsv_ready: got %b expected 0", rsv_ready); else pass_cnt++;
    total_cnt++; if ({wb_we, wb_addr, wb_data, wb_pc} !== 70'd0) $display("FAIL rst_wb: got we=%b addr=%h data=%h pc=%h expected all 0", wb_we, wb_addr, wb_data, wb_pc); else pass_cnt++;
    @(negedge clk);
    req_valid = '0; rsv_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
    req_pc    = {32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
    #1;
    total_cnt++; if (req_ready !== 3'b001) $display("FAIL rr_grant0: got %b expected 001", req_ready); else pass_cnt++;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL rr_we_before: got %b expected 0", wb_we); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (req_ready !== 3'b010) $display("FAIL rr_grant1: got %b expected 010", req_ready); else pass_cnt++;
    total_cnt++; if ({wb_we, wb_addr, wb_data, wb_pc} !== {1'b1, 5'd1, 32'hA0A0_A0A0, 32'h100}) $display("FAIL rr_wb0: got we=%b addr=%0d data=%h pc=%h expected 1/1/a0a0a0a0/100", wb_we, wb_addr, wb_data, wb_pc); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (req_ready !== 3'b100) $display("FAIL rr_grant2: got %b expected 100", req_ready); else pass_cnt++;
    total_cnt++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd2, 32'hA1A1_A1A1}) $display("FAIL rr_wb1: got we=%b addr=%0d data=%h expected 1/2/a1a1a1a1", wb_we, wb_addr, wb_data); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if ({wb_we, wb_addr, wb_data, wb_pc} !== {1'b1, 5'd3, 32'hA2A2_A2A2, 32'h108}) $display("FAIL rr_wb2: got we=%b addr=%0d data=%h pc=%h expected 1/3/a2a2a2a2/108", wb_we, wb_addr, wb_data, wb_pc); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL rr_we_after: got %b expected 0", wb_we); else pass_cnt++;
  endtask

  // Entry ptr=0; exits with ptr=2.
  task automatic test_reserve_forward();
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 5'd8; rs_addr = 5'd8; rt_addr = 5'd8;
    #1;
    total_cnt++; if ({rsv_ready, rs_busy} !== 2'b10) $display("FAIL fwd_rsv: got ready=%b busy=%b expected 1/0", rsv_ready, rs_busy); else pass_cnt++;
    @(negedge clk);
    rsv_valid = 1'b0;
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd8, 5'd0};
    req_data  = {32'd0, 32'h1234_5678, 32'd0};
    req_pc    = {32'd0, 32'h0000_0400, 32'd0};
    #1;
    total_cnt++; if ({rs_busy, rt_busy} !== 2'b11) $display("FAIL fwd_busy_pre: got rs=%b rt=%b expected 1/1", rs_busy, rt_busy); else pass_cnt++;
    total_cnt++; if (req_ready !== 3'b010) $display("FAIL fwd_grant: got %b expected 010", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if ({rs_fwd, rt_fwd, rs_busy} !== 3'b110) $display("FAIL fwd_flags: got fwd=%b%b busy=%b expected 11/0", rs_fwd, rt_fwd, rs_busy); else pass_cnt++;
    total_cnt++; if ({wb_data, wb_pc} !== {32'h1234_5678, 32'h400}) $display("FAIL fwd_data: got data=%h pc=%h expected 12345678/400", wb_data, wb_pc); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rs_fwd, rs_busy} !== 2'b00) $display("FAIL fwd_after: got fwd=%b busy=%b expected 0/0", rs_fwd, rs_busy); else pass_cnt++;
  endtask

  // Entry ptr=2; grant wraps to index 0; exits ptr=1 with busy[5]=1.
  task automatic test_reserve_blocked();
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 5'd5; rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
    total_cnt++; if (rsv_ready !== 1'b1) $display("FAIL blk_first: got %b expected 1", rsv_ready); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rsv_ready, rs_busy} !== 2'b01) $display("FAIL blk_held: got ready=%b busy=%b expected 0/1", rsv_ready, rs_busy); else pass_cnt++;
    @(negedge clk);
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd5};
    req_data  = {32'd0, 32'd0, 32'h0000_0055};
    #1;
    total_cnt++; if ({req_ready, rsv_ready} !== 4'b0010) $display("FAIL blk_grant: got ready=%b rsv=%b expected 001/0", req_ready, rsv_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if ({rsv_ready, wb_we, wb_addr} !== {1'b1, 1'b1, 5'd5}) $display("FAIL blk_release: got rsv=%b we=%b addr=%0d expected 1/1/5", rsv_ready, wb_we, wb_addr); else pass_cnt++;
    @(negedge clk);
    rsv_valid = 1'b0;
    #1;
    total_cnt++; if (rs_busy !== 1'b1) $display("FAIL blk_rebusy: got %b expected 1", rs_busy); else pass_cnt++;
  endtask

  // Entry ptr=1; exits ptr=2, busy[5] still 1.
  task automatic test_zero_write();
    @(negedge clk);
    rs_addr = 5'd0; rt_addr = 5'd5;
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {32'd0, 32'hFFFF_FFFF, 32'd0};
    #1;
    total_cnt++; if (req_ready !== 3'b010) $display("FAIL zero_ready: got %b expected 010", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if ({wb_we, rs_fwd, rs_busy, rt_busy} !== 4'b0001) $display("FAIL zero_effect: got we=%b fwd=%b rs_busy=%b rt_busy=%b expected 0/0/0/1", wb_we, rs_fwd, rs_busy, rt_busy); else pass_cnt++;
  endtask

  // Entry ptr=2; exits ptr=0 with busy[9]=1.
  task automatic test_concurrent();
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    #1;
    total_cnt++; if (rsv_ready !== 1'b1) $display("FAIL conc_rsv4: got %b expected 1", rsv_ready); else pass_cnt++;
    @(negedge clk);
    rsv_addr  = 5'd9;
    req_valid = 3'b100;
    req_addr  = {5'd4, 5'd0, 5'd0};
    req_data  = {32'hDEAD_0004, 32'd0, 32'd0};
    #1;
    total_cnt++; if ({rsv_ready, req_ready} !== 4'b1100) $display("FAIL conc_both: got rsv=%b ready=%b expected 1/100", rsv_ready, req_ready); else pass_cnt++;
    @(negedge clk);
    rsv_valid = 1'b0; req_valid = '0;
    rs_addr = 5'd9; rt_addr = 5'd4;
    #1;
    total_cnt++; if ({rs_busy, rt_busy, rt_fwd, rs_fwd} !== 4'b1010) $display("FAIL conc_result: got busy9=%b busy4=%b fwd4=%b fwd9=%b expected 1/0/1/0", rs_busy, rt_busy, rt_fwd, rs_fwd); else pass_cnt++;
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    @(negedge clk);
    rsv_valid = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd6, 5'd2, 5'd1};
    req_data  = {32'hC2, 32'hC1, 32'hC0};
    req_pc    = {32'h208, 32'h204, 32'h200};
    rs_addr = 5'd3; rt_addr = 5'd9;
    @(negedge clk); #1;
    total_cnt++; if ({rs_busy, wb_we, wb_addr} !== {1'b1, 1'b1, 5'd1}) $display("FAIL mid_pre: got busy3=%b we=%b addr=%0d expected 1/1/1", rs_busy, wb_we, wb_addr); else pass_cnt++;
    #1;
    reset = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    #1;
    total_cnt++; if ({wb_we, wb_addr, wb_data, wb_pc} !== 70'd0) $display("FAIL mid_wb: got we=%b addr=%h data=%h pc=%h expected all 0", wb_we, wb_addr, wb_data, wb_pc); else pass_cnt++;
    total_cnt++; if ({req_ready, rsv_ready, rs_busy, rt_busy} !== 6'b0) $display("FAIL mid_flags: got ready=%b rsv=%b busy3=%b busy9=%b expected 000/0/0/0", req_ready, rsv_ready, rs_busy, rt_busy); else pass_cnt++;
    @(negedge clk);
    rsv_valid = 1'b0;
    reset = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 3'b001) $display("FAIL mid_first_grant: got %b expected 001", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd1, 32'hC0}) $display("FAIL mid_first_wb: got we=%b addr=%0d data=%h expected 1/1/c0", wb_we, wb_addr, wb_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reserve_forward();
    test_reserve_blocked();
    test_zero_write();
    test_concurrent();
    test_reset_midburst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
